// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : UART transmitter. Each frame is a start bit, DATA_LEN data bits
// (LSB first), one parity bit and one stop bit. Every bit lasts 16 pulses of
// baud_tick_tx, which arrives at 16x the bit rate.
//
// Handshake: tx_start is a request. It is accepted on any clk edge where the
// transmitter is idle. tx_busy rises on that edge. Requests made while
// tx_busy=1 are dropped, not queued. tx_done pulses for one clk on the first
// idle cycle after the stop bit, and tx_busy is already low in that cycle.
// A tx_start in that same cycle is accepted, so frames can run back-to-back.
//
// Parameters:
//   DATA_LEN    - data bits per frame (5..9)
//   PARITY_TYPE - 1: even parity (XOR of data), 0: odd parity (XNOR of data)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   baud_tick_tx in   one-clk strobe at 16x the bit rate
//   tx_start     in   frame request
//   tx_data      in   payload, captured only when a request is accepted
//   tx_out       out  serial line, registered, idles high
//   tx_busy      out  frame in progress
//   tx_done      out  one-clk pulse at frame completion
//   dbg_state_o  out  current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_LEN    = 8,
    parameter int PARITY_TYPE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baud_tick_tx,
    input  logic                tx_start,
    input  logic [DATA_LEN-1:0] tx_data,
    output logic                tx_out,
    output logic                tx_busy,
    output logic                tx_done,
    output logic [2:0]          dbg_state_o
);

    localparam int BW = $clog2(DATA_LEN);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_LEN - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state_q,  state_d;
    logic [3:0]          tick_q,   tick_d;
    logic [BW-1:0]       bit_q,    bit_d;
    logic [DATA_LEN-1:0] shift_q,  shift_d;
    logic                parity_q, parity_d;
    logic                out_q,    out_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                bit_end;

    // A bit ends on the tick that takes the counter from 15 back to 0.
    // Because the counter wraps there, it is 0 on entry to every state.
    assign bit_end = baud_tick_tx && (tick_q == 4'd15);

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q != IDLE && baud_tick_tx) begin
            tick_d = tick_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d = tx_data;
                    // Parity is fixed at capture time. The shift register
                    // is consumed as the frame goes out.
                    parity_d = (PARITY_TYPE != 0) ? (^tx_data) : ~(^tx_data);
                    tick_d   = 4'd0;
                    bit_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // The line level is derived from the next state, so it changes on
        // the same edge as the state and stays glitch-free.
        case (state_d)
            START:   out_d = 1'b0;
            DATA:    out_d = shift_d[0];
            PARITY:  out_d = parity_d;
            default: out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= 4'd0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            out_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_out      = out_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx : directed and random frames on an even-parity and an
// odd-parity transmitter. The expected line level for every tick is derived
// from a list of frame bits built by the bench.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic       sel;
    logic [7:0] tx_data;
    logic [1:0] div  = 2'd0;
    logic       baud = 1'b0;

    logic e_out, e_busy, e_done, o_out, o_busy, o_done;
    logic [2:0] e_st, o_st;
    logic start_e, start_o;
    logic obs_out, obs_busy, obs_done;
    logic [2:0] obs_st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // One baud tick every 4 clks, registered so it is stable around the edges.
    always @(posedge clk) begin
        div  <= div + 2'd1;
        baud <= (div == 2'd3);
    end

    assign start_e  = tx_start & ~sel;
    assign start_o  = tx_start & sel;
    assign obs_out  = sel ? o_out  : e_out;
    assign obs_busy = sel ? o_busy : e_busy;
    assign obs_done = sel ? o_done : e_done;
    assign obs_st   = sel ? o_st   : e_st;

    uart_tx #(.DATA_LEN(8), .PARITY_TYPE(1)) u_even (
        .clk(clk), .rst(rst), .baud_tick_tx(baud), .tx_start(start_e),
        .tx_data(tx_data), .tx_out(e_out), .tx_busy(e_busy), .tx_done(e_done),
        .dbg_state_o(e_st)
    );

    uart_tx #(.DATA_LEN(8), .PARITY_TYPE(0)) u_odd (
        .clk(clk), .rst(rst), .baud_tick_tx(baud), .tx_start(start_o),
        .tx_data(tx_data), .tx_out(o_out), .tx_busy(o_busy), .tx_done(o_done),
        .dbg_state_o(o_st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame bits in line order: start, data LSB first, parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic odd);
        logic [10:0] b;
        int ones;
        ones = 0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b[1 + i] = d[i];
            ones += int'(d[i]);
        end
        b[9]  = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        b[10] = 1'b1;
        return b;
    endfunction

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (baud) ok = 1'b1;
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = d;
        @(posedge clk);
        #1 tx_start = 1'b0;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_out", obs_out, 1);
            chk("idle_busy", obs_busy, 0);
            chk("idle_done", obs_done, 0);
        end
    endtask

    // Follows an accepted frame tick by tick. At poke_at, a second request
    // with different data is made. At rst_at, reset is pulsed and the frame
    // is abandoned.
    task automatic run_frame(input logic [7:0] d, input int poke_at, input int rst_at);
        logic [10:0] bits;
        bit ok;
        bits = frame_bits(d, sel);
        for (int t = 0; t < 176; t++) begin
            wait_tick(ok);
            if (!ok) begin
                chk("tick_timeout", 0, 1);
                return;
            end
            chk($sformatf("tx_out_bit%0d", t / 16), obs_out, bits[t / 16]);
            chk("busy_in_frame", obs_busy, 1);
            chk("done_in_frame", obs_done, 0);
            if (t == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_async_out", obs_out, 1);
                chk("rst_async_busy", obs_busy, 0);
                chk("rst_async_done", obs_done, 0);
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            if (t == poke_at) begin
                tx_start = 1'b1;
                tx_data  = ~d;
                @(posedge clk);
                #1 tx_start = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_pulse", obs_done, 1);
        chk("done_busy", obs_busy, 0);
        chk("done_out", obs_out, 1);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] dir_bytes [4];
        dir_bytes[0] = 8'h00;
        dir_bytes[1] = 8'hFF;
        dir_bytes[2] = 8'h5A;
        dir_bytes[3] = 8'hC3;

        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        sel      = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset_out", obs_out, 1);
            chk("reset_busy", obs_busy, 0);
            chk("reset_done", obs_done, 0);
            chk("reset_state", obs_st, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_check(20);

        // Reference frame 8'hA5, even parity.
        start_frame(8'hA5);
        run_frame(8'hA5, -1, -1);
        idle_check(3);

        for (int i = 0; i < 4; i++) begin
            start_frame(dir_bytes[i]);
            run_frame(dir_bytes[i], -1, -1);
            idle_check(2);
        end

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            start_frame(d);
            run_frame(d, -1, -1);
            idle_check(1 + $urandom_range(0, 5));
        end

        // Odd-parity instance.
        sel = 1'b1;
        start_frame(8'h01);
        run_frame(8'h01, -1, -1);
        idle_check(2);
        start_frame(8'h03);
        run_frame(8'h03, -1, -1);
        idle_check(2);
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom_range(0, 255));
            start_frame(d);
            run_frame(d, -1, -1);
            idle_check(2);
        end
        sel = 1'b0;

        // A second request mid-frame is dropped.
        d = 8'($urandom_range(0, 255));
        start_frame(d);
        run_frame(d, 40, -1);
        idle_check(40);

        // Request held high: frames follow each other with no idle gap.
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h55;
        @(posedge clk);
        for (int f = 0; f < 3; f++) begin
            run_frame(8'h55, -1, -1);
        end
        tx_start = 1'b0;
        idle_check(10);

        // Reset during data bit 3, then a clean frame.
        d = 8'($urandom_range(0, 255));
        start_frame(d);
        run_frame(d, -1, 16 * 4 + 5);
        idle_check(40);
        start_frame(8'h81);
        run_frame(8'h81, -1, -1);
        idle_check(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
